serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//   Bit-serial adder. Computes a WIDTH-bit sum plus carry-out over WIDTH clock cycles.
//   Each cycle it feeds one operand bit pair and the stored carry into a single
//   FullAdder instance (ports a, b, cin, sum, carry), LSB first.
//   Sits directly upstream of the 1-bit FullAdder stage: it is the sequencer that
//   drives that stage and collects its sum/carry outputs.
//   Used where area matters more than latency.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range >= 2
//
// PORTS
//   clk     in   1       rising-edge clock
//   rst     in   1       asynchronous, active-high reset
//   start   in   1       request; sampled only in IDLE
//   a       in   WIDTH   operand A; captured when start is accepted
//   b       in   WIDTH   operand B; captured when start is accepted
//   cin     in   1       carry-in; captured when start is accepted
//   busy    out  1       high while an addition is in progress
//   done    out  1       one-cycle pulse: sum/carry updated with a new result
//   sum     out  WIDTH   registered result (a + b + cin) mod 2^WIDTH
//   carry   out  1       registered carry-out (bit WIDTH of a + b + cin)
//
// BEHAVIOUR
//   Reset (async, any time): state=IDLE; busy=0, done=0, sum=0, carry=0.
//     All internal shift registers, the carry register and the counter are cleared.
//   States: IDLE, RUN.
//   IDLE: on a rising edge with start=1:
//     - load a_sh=a, b_sh=b, c_reg=cin, acc=0, cnt=0
//     - go to RUN, busy<=1
//     - start=0 stays in IDLE.
//   RUN: every edge:
//     - fa inputs: a_sh[0], b_sh[0], c_reg
//     - acc <= {fa.sum, acc[WIDTH-1:1]}; a_sh, b_sh shift right by 1
//     - c_reg <= fa.carry; cnt <= cnt+1
//   Completion: on the edge where cnt==WIDTH-1:
//     - sum <= {fa.sum, acc[WIDTH-1:1]}; carry <= fa.carry
//     - done <= 1; busy <= 0; go to IDLE
//   Latency: start sampled at edge E0; done/sum/carry are valid after edge E(WIDTH).
//     Exactly WIDTH cycles; throughput is one add per WIDTH cycles.
//   done is high for exactly one cycle; it is cleared on the next edge unless a new
//     completion occurs.
//   sum/carry change only at completion; between results they hold the previous
//     result (partial bits are never visible).
//   start while busy=1 is ignored: no queueing, no effect on the current operation.
//   start in the same cycle done=1 is accepted (state is IDLE); back-to-back adds
//     have no idle gap.
//   a, b, cin may change freely after acceptance; only the captured values are used.
//   Reset mid-RUN aborts the operation: no done pulse, sum/carry return to 0.
//   Counter width: $clog2(WIDTH); wrap-around is never reached because RUN exits
//     at WIDTH-1.
//
// TESTING
//   1. WIDTH=8, a=8'h00, b=8'h00, cin=0, pulse start
//      -> done after exactly 8 cycles; sum=8'h00, carry=0.
//   2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1.
//      Then a=8'hA5, b=8'h5A, cin=1 issued on the done cycle
//      -> accepted, sum=8'h00, carry=1 eight cycles later.
//   3. a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, carry=0.
//      Check: busy high 8 cycles, done high 1 cycle, sum held at 8'h4B afterwards.
//   4. Start a=8'h12, b=8'h34; pulse start again 3 cycles later with a=8'hFF, b=8'hFF
//      -> second start ignored; sum=8'h46, carry=0; only one done pulse.
//   5. Start a=8'h80, b=8'h80; assert rst 4 cycles in
//      -> busy=0, done=0, sum=0, carry=0 immediately; no done pulse afterwards.
//      New start after reset completes normally.
//   6. Random: 1000 random a, b, cin values, compared against the golden model
//      {carry,sum} = a+b+cin. Repeat at WIDTH=2 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, sequenced LSB first over WIDTH cycles.
// sum/carry are registered and change only when a result completes.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Bit 0 of the accumulator would only ever hold a discarded zero, so it is not stored.
  logic [WIDTH-1:1] acc;
  logic [WIDTH-1:0] acc_next;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;

  logic load;
  logic step;
  logic finish;
  logic fa_sum;
  logic fa_carry;

  full_adder fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_reg),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign acc_next = {fa_sum, acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      acc   <= '0;
      c_reg <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_next[WIDTH-1:1];
      c_reg <= fa_carry;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers only load on the final bit, so partial sums never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (finish) begin
        sum   <= acc_next;
        carry <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH 8, 2 and 16 against an arithmetic model.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, cin8, busy8, done8, carry8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, cin2, busy2, done2, carry2;
  logic [1:0]  a2, b2, sum2;
  logic        start16, cin16, busy16, done16, carry16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;

  logic [8:0]  q8[$];
  logic [2:0]  q2[$];
  logic [16:0] q16[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      logic [8:0] e;
      done_cnt8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_done: got done=1 expected no pending result");
      end else begin
        e = q8.pop_front();
        check("w8_result", 64'({carry8, sum8}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      logic [2:0] e;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w2_unexpected_done: got done=1 expected no pending result");
      end else begin
        e = q2.pop_front();
        check("w2_result", 64'({carry2, sum2}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      logic [16:0] e;
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w16_unexpected_done: got done=1 expected no pending result");
      end else begin
        e = q16.pop_front();
        check("w16_result", 64'({carry16, sum16}), 64'(e));
      end
    end
  end

  // Issue one add, scramble the inputs after acceptance, wait for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int lat, output int bcnt);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8 === 1'b1) bcnt++;
    end
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c, output int lat);
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + 3'(c));
    @(posedge clk); #1;
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    q16.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    lat = 0;
    while (done16 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, d0;
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    #2 rst = 1'b1;
    #20;
    check("reset_busy", 64'(busy8), 64'(0));
    check("reset_done", 64'(done8), 64'(0));
    check("reset_sum", 64'(sum8), 64'(0));
    check("reset_carry", 64'(carry8), 64'(0));
    check("reset_w16_sum", 64'({carry16, sum16}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero operands, exact latency
    run8(8'h00, 8'h00, 1'b0, lat, bc);
    check("t1_latency", 64'(lat), 64'(8));

    // Overflow, then a start issued on the done cycle
    run8(8'hFF, 8'h01, 1'b0, lat, bc);
    check("t2a_latency", 64'(lat), 64'(8));
    run8(8'hA5, 8'h5A, 1'b1, lat, bc);
    check("t2b_latency", 64'(lat), 64'(8));
    check("t2b_sum", 64'(sum8), 64'(8'h00));
    check("t2b_carry", 64'(carry8), 64'(1));

    // Busy width, done width, result hold
    run8(8'h3C, 8'h0F, 1'b0, lat, bc);
    check("t3_latency", 64'(lat), 64'(8));
    check("t3_busy_cycles", 64'(bc), 64'(8));
    check("t3_sum", 64'(sum8), 64'(8'h4B));
    @(posedge clk); #1;
    check("t3_done_cleared", 64'(done8), 64'(0));
    check("t3_busy_idle", 64'(busy8), 64'(0));
    repeat (5) begin @(posedge clk); #1; end
    check("t3_sum_held", 64'(sum8), 64'(8'h4B));
    check("t3_carry_held", 64'(carry8), 64'(0));

    // Start while busy is ignored
    d0 = done_cnt8;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h046);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("t4_finish_cycle", 64'(lat), 64'(5));
    check("t4_sum", 64'(sum8), 64'(8'h46));
    repeat (12) begin @(posedge clk); #1; end
    check("t4_done_pulses", 64'(done_cnt8 - d0), 64'(1));

    // Reset mid-run aborts
    d0 = done_cnt8;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("t5_busy", 64'(busy8), 64'(0));
    check("t5_done", 64'(done8), 64'(0));
    check("t5_sum", 64'(sum8), 64'(0));
    check("t5_carry", 64'(carry8), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("t5_no_done", 64'(done_cnt8 - d0), 64'(0));
    check("t5_busy_after", 64'(busy8), 64'(0));
    run8(8'h80, 8'h80, 1'b0, lat, bc);
    check("t5_restart_latency", 64'(lat), 64'(8));
    check("t5_restart_result", 64'({carry8, sum8}), 64'(9'h100));

    // Random, back-to-back at each width
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), lat, bc);
      if (lat != 8) check("w8_random_latency", 64'(lat), 64'(8));
    end
    for (int i = 0; i < 1000; i++) begin
      run2(2'($urandom), 2'($urandom), 1'($urandom), lat);
      if (lat != 2) check("w2_random_latency", 64'(lat), 64'(2));
    end
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), lat);
      if (lat != 16) check("w16_random_latency", 64'(lat), 64'(16));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("q8_drained", 64'(q8.size()), 64'(0));
    check("q2_drained", 64'(q2.size()), 64'(0));
    check("q16_drained", 64'(q16.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
